// File: rtl/rename_ctrl.sv
// Rename/commit sequencer: hands out circular ROB tags to decode and drives the regfile rename/write ports.
// Latency: upd/write pulse 1 cycle after the accepting edge; dec_ready/alloc_idx are combinational.
// Backpressure: dec_ready drops when all ROB_SIZE tags are in flight; rdy=0 freezes all state and outputs.
//
// Build option: define RENAME_FULL_BYPASS_EN to let an in-order commit free a tag for a same-cycle
// allocation while the ROB is full (count stays at ROB_SIZE).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable (low = freeze)
//   jp_wrong            misprediction flush, highest priority
//   dec_*               decoder offer; handshake on dec_valid && dec_ready, tag = alloc_idx
//   cmt_*               in-order commit from the ROB
//   upd/upd_idx/upd_rd  registered rename port
//   write/write_idx/write_rd/new_val  registered write port
//   cmt_err             sticky out-of-order/empty commit flag, cleared only by rst
module rename_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jp_wrong,
  input  logic             dec_valid,
  input  logic             dec_has_rd,
  input  logic [4:0]       dec_rd,
  output logic             dec_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             cmt_valid,
  input  logic [IDX_W-1:0] cmt_idx,
  input  logic             cmt_has_rd,
  input  logic [4:0]       cmt_rd,
  input  logic [31:0]      cmt_val,
  output logic             upd,
  output logic [IDX_W-1:0] upd_idx,
  output logic [4:0]       upd_rd,
  output logic             write,
  output logic [IDX_W-1:0] write_idx,
  output logic [4:0]       write_rd,
  output logic [31:0]      new_val,
  output logic             cmt_err
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ROB_SIZE);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic cmt_ok;    // commit matches head of a non-empty ROB
  logic space_ok;  // a tag can be handed out this cycle
  logic alloc;
  logic commit;

  assign cmt_ok = cmt_valid && (cmt_idx == head) && (count != '0);

`ifdef RENAME_FULL_BYPASS_EN
  // The tag retiring this cycle is recycled straight into the new allocation.
  assign space_ok = (count < FULL) || cmt_ok;
`else
  assign space_ok = (count < FULL);
`endif

  assign dec_ready = !rst && rdy && !jp_wrong && space_ok;
  assign alloc_idx = tail;
  assign alloc     = dec_valid && dec_ready;
  assign commit    = !rst && rdy && !jp_wrong && cmt_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      upd_rd    <= '0;
      write     <= 1'b0;
      write_idx <= '0;
      write_rd  <= '0;
      new_val   <= '0;
      cmt_err   <= 1'b0;
    end else if (rdy) begin
      if (jp_wrong) begin
        // Flush discards any handshake or commit presented in the same cycle.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        upd   <= 1'b0;
        write <= 1'b0;
      end else begin
        // Tags with no real destination (none, or x0) are still consumed but never renamed.
        upd <= alloc && dec_has_rd && (dec_rd != 5'd0);
        if (alloc) begin
          tail    <= tail + 1'b1;
          upd_idx <= tail;
          upd_rd  <= dec_rd;
        end

        write <= commit && cmt_has_rd && (cmt_rd != 5'd0);
        if (commit) begin
          head      <= head + 1'b1;
          write_idx <= cmt_idx;
          write_rd  <= cmt_rd;
          new_val   <= cmt_val;
        end

        if (cmt_valid && !cmt_ok)
          cmt_err <= 1'b1;

        case ({alloc, commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Bench for rename_ctrl: directed scenarios followed by random traffic, checked against a queue model.
// Latency: one model step per clock; outputs compared #1 after the edge.
// Backpressure: model decides readiness from its own occupancy, including the full-bypass build option.
module tb_rename_ctrl;

  localparam int ROB = 16;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, jp_wrong;
  logic          dec_valid, dec_has_rd;
  logic [4:0]    dec_rd;
  logic          dec_ready;
  logic [IW-1:0] alloc_idx;
  logic          cmt_valid;
  logic [IW-1:0] cmt_idx;
  logic          cmt_has_rd;
  logic [4:0]    cmt_rd;
  logic [31:0]   cmt_val;
  logic          upd;
  logic [IW-1:0] upd_idx;
  logic [4:0]    upd_rd;
  logic          write;
  logic [IW-1:0] write_idx;
  logic [4:0]    write_rd;
  logic [31:0]   new_val;
  logic          cmt_err;

  rename_ctrl #(.ROB_SIZE(ROB), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .dec_valid(dec_valid), .dec_has_rd(dec_has_rd), .dec_rd(dec_rd),
    .dec_ready(dec_ready), .alloc_idx(alloc_idx),
    .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_has_rd(cmt_has_rd),
    .cmt_rd(cmt_rd), .cmt_val(cmt_val),
    .upd(upd), .upd_idx(upd_idx), .upd_rd(upd_rd),
    .write(write), .write_idx(write_idx), .write_rd(write_rd), .new_val(new_val),
    .cmt_err(cmt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: the in-flight tags as an ordered list, plus the next tag to issue.
  int          q[$];
  int          m_tail;
  bit          e_upd, e_wr, e_err;
  int          e_upd_idx, e_upd_rd, e_wr_idx, e_wr_rd;
  logic [31:0] e_val;

  task automatic model_reset();
    q.delete();
    m_tail = 0; e_upd = 0; e_wr = 0; e_err = 0;
    e_upd_idx = 0; e_upd_rd = 0; e_wr_idx = 0; e_wr_rd = 0; e_val = '0;
  endtask

  task automatic check_regs(input string when);
    chk({when, ":upd"}, 32'(upd), 32'(e_upd));
    if (e_upd) begin
      chk({when, ":upd_idx"}, 32'(upd_idx), 32'(e_upd_idx));
      chk({when, ":upd_rd"}, 32'(upd_rd), 32'(e_upd_rd));
    end
    chk({when, ":write"}, 32'(write), 32'(e_wr));
    if (e_wr) begin
      chk({when, ":write_idx"}, 32'(write_idx), 32'(e_wr_idx));
      chk({when, ":write_rd"}, 32'(write_rd), 32'(e_wr_rd));
      chk({when, ":new_val"}, new_val, e_val);
    end
    chk({when, ":cmt_err"}, 32'(cmt_err), 32'(e_err));
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; jp_wrong = 0; dec_valid = 1; dec_has_rd = 1; dec_rd = 5'd9;
    cmt_valid = 0; cmt_idx = '0; cmt_has_rd = 0; cmt_rd = '0; cmt_val = '0;
    @(posedge clk); #1;
    chk("rst:dec_ready", 32'(dec_ready), 32'd0);
    chk("rst:upd_idx", 32'(upd_idx), 32'd0);
    chk("rst:upd_rd", 32'(upd_rd), 32'd0);
    chk("rst:write_idx", 32'(write_idx), 32'd0);
    chk("rst:write_rd", 32'(write_rd), 32'd0);
    chk("rst:new_val", new_val, 32'd0);
    model_reset();
    check_regs("rst");
    rst = 0; dec_valid = 0;
  endtask

  // One clock: compare combinational outputs, advance the model, compare registered outputs.
  task automatic tick();
    bit byp, exp_rdy, hs, cok;
    #1;
    byp = 0;
`ifdef RENAME_FULL_BYPASS_EN
    byp = (q.size() == ROB) && cmt_valid && (int'(cmt_idx) == q[0]);
`endif
    exp_rdy = rdy && !jp_wrong && ((q.size() < ROB) || byp);
    chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
    if (exp_rdy) chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
    hs  = dec_valid && exp_rdy;
    cok = cmt_valid && (q.size() > 0) && (int'(cmt_idx) == q[0]);
    @(posedge clk);
    if (rdy) begin
      if (jp_wrong) begin
        q.delete(); m_tail = 0; e_upd = 0; e_wr = 0;
      end else begin
        if (cmt_valid && !cok) e_err = 1;
        e_wr = cok && cmt_has_rd && (cmt_rd != 0);
        if (cok) begin
          void'(q.pop_front());
          e_wr_idx = int'(cmt_idx); e_wr_rd = int'(cmt_rd); e_val = cmt_val;
        end
        e_upd = hs && dec_has_rd && (dec_rd != 0);
        if (hs) begin
          e_upd_idx = m_tail; e_upd_rd = int'(dec_rd);
          q.push_back(m_tail);
          m_tail = (m_tail + 1) % ROB;
        end
      end
    end
    #1;
    check_regs("cyc");
  endtask

  task automatic drv(input bit r, input bit jw, input bit dv, input bit dh, input int drd,
                     input bit cv, input int ci, input bit ch, input int crd, input logic [31:0] cval);
    rdy = r; jp_wrong = jw; dec_valid = dv; dec_has_rd = dh; dec_rd = 5'(drd);
    cmt_valid = cv; cmt_idx = IW'(ci); cmt_has_rd = ch; cmt_rd = 5'(crd); cmt_val = cval;
    tick();
  endtask

  function automatic int head_tag();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  initial begin
    do_reset();

    // Three allocations, rd 5/0/7: idx 1 consumed silently.
    drv(1, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 7, 0, 0, 0, 0, 0);

    // Fill to ROB_SIZE, then hold dec_valid against a full ROB.
    for (int i = 0; i < ROB - 3; i++) drv(1, 0, 1, 1, $urandom_range(31), 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 4, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 4, 1, 0, 1, 3, 32'hCAFE_0000);
    drv(1, 0, 1, 1, 6, 0, 0, 0, 0, 0);

    // Bring occupancy to 9, then flush with a colliding handshake and commit.
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drv(1, 0, 1, 1, i + 1, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 1, 12, 1, 0, 1, 12, 32'h1234);
    drv(1, 0, 1, 1, 13, 0, 0, 0, 0, 0);

    // Steady alloc+commit across tag wrap.
    for (int i = 0; i < 40; i++)
      drv(1, 0, 1, 1, $urandom_range(31), 1, head_tag(), 1, $urandom_range(1, 31), $urandom);

    // Freeze straight after a handshake, then resume.
    drv(1, 0, 1, 1, 21, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(0, 0, 1, 1, 22, 1, head_tag(), 1, 9, 32'hDEAD);
    drv(1, 0, 1, 1, 23, 1, head_tag(), 1, 9, 32'hBEEF);

    // Out-of-order commit: tag 3 while head is 0.
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 3, 1, 5, 32'h55);
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int ci;
      ci = (($urandom % 16) == 0) ? int'($urandom_range(ROB - 1)) : head_tag();
      drv(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0, $urandom % 2,
          (($urandom % 4) == 0) ? 0 : int'($urandom_range(31)),
          ($urandom % 3) != 0, ci, $urandom % 2,
          (($urandom % 4) == 0) ? 0 : int'($urandom_range(31)), $urandom);
    end

    // Commit into an empty ROB after reset, then reset clears the sticky flag.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 4, 32'h77);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drv(1, 0, 1, 1, 3, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
